// File: rtl/display_capture.sv
// display_capture
//   Receiver for a four-digit multiplexed seven-segment scan bus. The bus
//   carries an active-low one-hot digit enable (AN) and the nibble for that
//   digit (displaydata). The block samples the bus and filters glitches with
//   a stability counter. It checks that digits arrive in the order
//   3, 2, 1, 0 and rebuilds the 16-bit value shown on the display.
//
//   Parameters
//     STABLE_CYCLES : consecutive identical samples needed to accept a digit
//                     (1..255)
//     CNT_W         : stability counter width, 2**CNT_W > STABLE_CYCLES
//
//   Ports
//     CLK         in   system clock, rising edge
//     Reset       in   asynchronous active-low reset
//     AN          in   [3:0] digit enables, active-low one-hot
//     displaydata in   [3:0] nibble for the enabled digit
//     display     out  [15:0] last committed frame (digit 3 in [15:12])
//     frame_valid out  one-cycle pulse when display is committed
//     frame_error out  one-cycle pulse on an illegal AN or an out-of-order digit
//     synced      out  high while a frame is being collected
module display_capture #(
  parameter int STABLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [3:0]  AN,
  input  logic [3:0]  displaydata,
  output logic [15:0] display,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        synced
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    EXP2      = 2'd1,
    EXP1      = 2'd2,
    EXP0      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [7:0]       smp_q, smp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      display_q, display_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;
  state_t           state_q, state_d;

  logic [7:0]       in_w;
  logic             same_w;
  logic             an_legal;
  logic             an_blank;
  logic [1:0]       an_idx;
  logic [3:0]       nib;

  // Sampling and stability stage
  assign in_w   = {AN, displaydata};
  assign same_w = (in_w == smp_q);

  always_comb begin
    smp_d = in_w;
    cnt_d = same_w ? sat_inc(cnt_q) : CNT_ONE;
    // Accept only on the transition into STABLE_C. The second term keeps a
    // count that saturates at STABLE_C from accepting again, and still lets
    // STABLE_CYCLES == 1 accept every change of input.
    acc_d = (cnt_d == STABLE_C) && (!same_w || (cnt_q != STABLE_C));
  end

  // Decode stage: works on the accepted sample held in smp_q
  assign nib = smp_q[3:0];

  always_comb begin
    an_legal = 1'b0;
    an_blank = 1'b0;
    an_idx   = 2'd0;
    case (smp_q[7:4])
      4'b0111: begin an_legal = 1'b1; an_idx = 2'd3; end
      4'b1011: begin an_legal = 1'b1; an_idx = 2'd2; end
      4'b1101: begin an_legal = 1'b1; an_idx = 2'd1; end
      4'b1110: begin an_legal = 1'b1; an_idx = 2'd0; end
      4'b1111: an_blank = 1'b1;
      default: ;
    endcase
  end

  // Frame assembly FSM
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    if (acc_q && !an_blank) begin
      if (!an_legal) begin
        fe_d    = 1'b1;
        state_d = WAIT_SYNC;
      end else begin
        case (state_q)
          WAIT_SYNC: begin
            // Digits other than 3 are ignored while looking for a frame start.
            if (an_idx == 2'd3) begin
              shadow_d[15:12] = nib;
              state_d         = EXP2;
            end
          end
          EXP2: begin
            if (an_idx == 2'd2) begin
              shadow_d[11:8] = nib;
              state_d        = EXP1;
            end else if (an_idx == 2'd3) begin
              shadow_d[15:12] = nib;
              fe_d            = 1'b1;
              state_d         = EXP2;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_SYNC;
            end
          end
          EXP1: begin
            if (an_idx == 2'd1) begin
              shadow_d[7:4] = nib;
              state_d       = EXP0;
            end else if (an_idx == 2'd3) begin
              shadow_d[15:12] = nib;
              fe_d            = 1'b1;
              state_d         = EXP2;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_SYNC;
            end
          end
          EXP0: begin
            if (an_idx == 2'd0) begin
              display_d = {shadow_q[15:4], nib};
              fv_d      = 1'b1;
              state_d   = WAIT_SYNC;
            end else if (an_idx == 2'd3) begin
              shadow_d[15:12] = nib;
              fe_d            = 1'b1;
              state_d         = EXP2;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_SYNC;
            end
          end
          default: state_d = WAIT_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      smp_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      shadow_q  <= '0;
      display_q <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      state_q   <= WAIT_SYNC;
    end else begin
      smp_q     <= smp_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
      state_q   <= state_d;
    end
  end

  assign display     = display_q;
  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign synced      = (state_q != WAIT_SYNC);

endmodule
